// File: rtl/multi_pushbutton_processor.sv
// multi_pushbutton_processor
//   N-channel pushbutton front end. Each channel is synchronised (2 flops),
//   debounced, and classified as a short or long press. Long presses can
//   optionally auto-repeat while the button stays held. After reset every
//   channel is locked out until its button has been seen released, so a
//   button held through reset is ignored until it is let go.
//
// Ports
//   clk_1khz      in   1          1 kHz tick clock, rising edge
//   rst_i         in   1          asynchronous, active-high reset
//   pushbutton_i  in   N_BUTTONS  raw button levels, 1 = pressed
//   held_o        out  N_BUTTONS  debounced button level
//   short_o       out  N_BUTTONS  1-cycle pulse: released before long threshold
//   long_o        out  N_BUTTONS  1-cycle pulse: long threshold / repeat interval
module multi_pushbutton_processor #(
  parameter int unsigned N_BUTTONS     = 2,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 2000,
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_MS     = 250
) (
  input  logic                 clk_1khz,
  input  logic                 rst_i,
  input  logic [N_BUTTONS-1:0] pushbutton_i,
  output logic [N_BUTTONS-1:0] held_o,
  output logic [N_BUTTONS-1:0] short_o,
  output logic [N_BUTTONS-1:0] long_o
);

  localparam int unsigned DW       = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned HOLD_MAX = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_PRESS_MS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_MS - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG
  } state_t;

  logic [N_BUTTONS-1:0] sync1;
  logic [N_BUTTONS-1:0] sync2;

  always_ff @(posedge clk_1khz or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pushbutton_i;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    logic          lockout;
    logic [DW-1:0] lock_cnt;
    logic [DW-1:0] deb_cnt;
    logic          held_q;
    logic          rise;
    logic          fall;
    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [HW-1:0] hold_inc;
    logic          long_hit;
    logic          short_q;
    logic          short_d;
    logic          long_q;
    logic          long_d;

    // Release is judged on both sync flops so the reset value of sync2 cannot
    // masquerade as a released button while a held level is still in flight.
    always_ff @(posedge clk_1khz or posedge rst_i) begin
      if (rst_i) begin
        lockout  <= 1'b1;
        lock_cnt <= '0;
      end else if (lockout) begin
        if (sync1[g] || sync2[g]) begin
          lock_cnt <= '0;
        end else if (lock_cnt == DEB_LAST) begin
          lockout  <= 1'b0;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end
    end

    // Debounce accept: the edge on which the disagreement counter would reach
    // DEBOUNCE_MS toggles the debounced level.
    always_comb begin
      rise = 1'b0;
      fall = 1'b0;
      if (!lockout && (sync2[g] != held_q) && (deb_cnt == DEB_LAST)) begin
        rise = sync2[g];
        fall = !sync2[g];
      end
    end

    always_ff @(posedge clk_1khz or posedge rst_i) begin
      if (rst_i) begin
        deb_cnt <= '0;
        held_q  <= 1'b0;
      end else begin
        if (lockout || (sync2[g] == held_q) || (deb_cnt == DEB_LAST)) begin
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
        if (rise) begin
          held_q <= 1'b1;
        end else if (fall) begin
          held_q <= 1'b0;
        end
      end
    end

    assign hold_inc = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
    assign long_hit = ((state_q == ST_PRESSED) && (hold_q == LONG_LAST)) ||
                      (REPEAT_EN && (state_q == ST_LONG) && (hold_q == REP_LAST));

    // State register
    always_ff @(posedge clk_1khz or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        short_q <= short_d;
        long_q  <= long_d;
      end
    end

    // Next state
    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_IDLE:    if (rise) state_d = ST_PRESSED;
        ST_PRESSED: begin
          if (fall) begin
            state_d = ST_IDLE;
          end else if (long_hit) begin
            state_d = ST_LONG;
          end
        end
        ST_LONG:    if (fall) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end

    // Outputs and hold counter; a long hit outranks a coincident release.
    always_comb begin
      hold_d  = hold_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      case (state_q)
        ST_IDLE: hold_d = '0;
        ST_PRESSED: begin
          hold_d = hold_inc;
          if (long_hit) begin
            long_d = 1'b1;
            hold_d = '0;
          end else if (fall) begin
            short_d = 1'b1;
          end
        end
        ST_LONG: begin
          hold_d = hold_inc;
          if (long_hit) begin
            long_d = 1'b1;
            hold_d = '0;
          end
        end
        default: hold_d = '0;
      endcase
    end

    assign held_o[g]  = held_q;
    assign short_o[g] = short_q;
    assign long_o[g]  = long_q;
  end

endmodule

// File: tb/tb_multi_pushbutton_processor.sv
module tb_multi_pushbutton_processor;

  localparam int unsigned NB = 2;
  localparam int unsigned D  = 20;
  localparam int unsigned L  = 2000;
  localparam int unsigned R  = 250;
  localparam int unsigned LAT = D + 2;   // input change -> held_o change, in edges

  localparam int unsigned K_RISE  = 0;
  localparam int unsigned K_FALL  = 1;
  localparam int unsigned K_SHORT = 2;
  localparam int unsigned K_LONG  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] pb_a, held_a, short_a, long_a;
  logic [NB-1:0] pb_b, held_b, short_b, long_b;

  always #5 clk = ~clk;

  multi_pushbutton_processor #(
    .N_BUTTONS(NB), .DEBOUNCE_MS(D), .LONG_PRESS_MS(L), .REPEAT_EN(1'b0), .REPEAT_MS(R)
  ) dut_a (
    .clk_1khz(clk), .rst_i(rst), .pushbutton_i(pb_a),
    .held_o(held_a), .short_o(short_a), .long_o(long_a)
  );

  multi_pushbutton_processor #(
    .N_BUTTONS(NB), .DEBOUNCE_MS(D), .LONG_PRESS_MS(L), .REPEAT_EN(1'b1), .REPEAT_MS(R)
  ) dut_b (
    .clk_1khz(clk), .rst_i(rst), .pushbutton_i(pb_b),
    .held_o(held_b), .short_o(short_b), .long_o(long_b)
  );

  typedef struct {
    int unsigned key;
    int unsigned cyc;
    int unsigned d;
    int unsigned ch;
    int unsigned kind;
  } ev_t;

  typedef struct {
    int unsigned d;
    int unsigned ch;
    int unsigned dur;
    bit          exp_held;
    bit          exp_short;
    int unsigned exp_long;
  } vec_t;

  ev_t         exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int unsigned k);
    case (k)
      K_RISE:  return "held_rise";
      K_FALL:  return "held_fall";
      K_SHORT: return "short";
      default: return "long";
    endcase
  endfunction

  // Keep the expectation queue in the same order the monitor reports events.
  function automatic void expect_ev(int unsigned d, int unsigned ch, int unsigned kind, int unsigned c);
    ev_t e;
    int unsigned idx;
    e.cyc  = c;
    e.d    = d;
    e.ch   = ch;
    e.kind = kind;
    e.key  = c * 64 + d * 32 + ch * 4 + kind;
    idx = exp_q.size();
    while (idx > 0 && exp_q[idx-1].key > e.key) idx--;
    exp_q.insert(idx, e);
  endfunction

  function automatic void got_ev(int unsigned d, int unsigned ch, int unsigned kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got dut%0d ch%0d %s @%0d, required no event", d, ch, kname(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.d != d || e.ch != ch || e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got dut%0d ch%0d %s @%0d, required dut%0d ch%0d %s @%0d",
                 d, ch, kname(kind), cyc, e.d, e.ch, kname(e.kind), e.cyc);
      end
    end
  endfunction

  task automatic chk(string name, logic [NB-1:0] act, logic [NB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic tick(int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pb(int unsigned d, int unsigned ch, logic v);
    if (d == 0) pb_a[ch] = v;
    else        pb_b[ch] = v;
  endtask

  // Monitor: every reported event is matched against the scoreboard.
  initial begin
    logic [NB-1:0] prev_a, prev_b;
    prev_a = '0;
    prev_b = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_a = '0;
        prev_b = '0;
      end else begin
        for (int ch = 0; ch < NB; ch++) begin
          if (held_a[ch] && !prev_a[ch]) got_ev(0, ch, K_RISE);
          if (!held_a[ch] && prev_a[ch]) got_ev(0, ch, K_FALL);
          if (short_a[ch])               got_ev(0, ch, K_SHORT);
          if (long_a[ch])                got_ev(0, ch, K_LONG);
        end
        for (int ch = 0; ch < NB; ch++) begin
          if (held_b[ch] && !prev_b[ch]) got_ev(1, ch, K_RISE);
          if (!held_b[ch] && prev_b[ch]) got_ev(1, ch, K_FALL);
          if (short_b[ch])               got_ev(1, ch, K_SHORT);
          if (long_b[ch])                got_ev(1, ch, K_LONG);
        end
        prev_a = held_a;
        prev_b = held_b;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    int unsigned bw[6];
    int unsigned p, k, e;

    vecs[0] = '{d: 0, ch: 0, dur: 19,   exp_held: 0, exp_short: 0, exp_long: 0};
    vecs[1] = '{d: 0, ch: 0, dur: 20,   exp_held: 1, exp_short: 1, exp_long: 0};
    vecs[2] = '{d: 0, ch: 1, dur: 30,   exp_held: 1, exp_short: 1, exp_long: 0};
    vecs[3] = '{d: 0, ch: 0, dur: 1999, exp_held: 1, exp_short: 1, exp_long: 0};
    vecs[4] = '{d: 0, ch: 0, dur: 2000, exp_held: 1, exp_short: 0, exp_long: 1};
    vecs[5] = '{d: 0, ch: 1, dur: 2100, exp_held: 1, exp_short: 0, exp_long: 1};
    vecs[6] = '{d: 1, ch: 1, dur: 2600, exp_held: 1, exp_short: 0, exp_long: 3};
    vecs[7] = '{d: 1, ch: 0, dur: 30,   exp_held: 1, exp_short: 1, exp_long: 0};

    // Reset with ch0 already pressed
    rst  = 1'b1;
    pb_a = '0;
    pb_b = '0;
    pb_a[0] = 1'b1;
    tick(3);
    chk("reset_held_a",  held_a,  '0);
    chk("reset_short_a", short_a, '0);
    chk("reset_long_a",  long_a,  '0);
    chk("reset_held_b",  held_b,  '0);
    chk("reset_short_b", short_b, '0);
    chk("reset_long_b",  long_b,  '0);
    rst = 1'b0;

    // Lockout: the held-through-reset press is ignored, the next one counts
    tick(100);
    chk("lockout_held", held_a, '0);
    pb_a[0] = 1'b0;
    tick(100);
    p = cyc;
    expect_ev(0, 0, K_RISE, p + LAT);
    expect_ev(0, 0, K_FALL, p + 30 + LAT);
    expect_ev(0, 0, K_SHORT, p + 30 + LAT);
    pb_a[0] = 1'b1;
    tick(30);
    pb_a[0] = 1'b0;
    tick(60);

    // Table of single presses
    for (int unsigned i = 0; i < 8; i++) begin
      p = cyc;
      if (vecs[i].exp_held) begin
        expect_ev(vecs[i].d, vecs[i].ch, K_RISE, p + LAT);
        expect_ev(vecs[i].d, vecs[i].ch, K_FALL, p + vecs[i].dur + LAT);
        if (vecs[i].exp_short)
          expect_ev(vecs[i].d, vecs[i].ch, K_SHORT, p + vecs[i].dur + LAT);
        for (int unsigned j = 0; j < vecs[i].exp_long; j++)
          expect_ev(vecs[i].d, vecs[i].ch, K_LONG, p + LAT + L + j * R);
      end
      set_pb(vecs[i].d, vecs[i].ch, 1'b1);
      tick(vecs[i].dur);
      set_pb(vecs[i].d, vecs[i].ch, 1'b0);
      tick(D + 40);
    end

    // Bounce on press: 1-2 ms chatter, then stable 30 ms
    bw = '{1, 2, 1, 2, 1, 1};
    for (int unsigned i = 0; i < 6; i++) begin
      pb_a[0] = (i % 2 == 0);
      tick(bw[i]);
    end
    k = cyc;
    expect_ev(0, 0, K_RISE, k + LAT);
    expect_ev(0, 0, K_FALL, k + 30 + LAT);
    expect_ev(0, 0, K_SHORT, k + 30 + LAT);
    pb_a[0] = 1'b1;
    tick(30);
    pb_a[0] = 1'b0;
    tick(60);

    // Long press with bouncy release
    p = cyc;
    expect_ev(0, 0, K_RISE, p + LAT);
    expect_ev(0, 0, K_LONG, p + LAT + L);
    pb_a[0] = 1'b1;
    tick(2100);
    pb_a[0] = 1'b0; tick(2);
    pb_a[0] = 1'b1; tick(1);
    pb_a[0] = 1'b0; tick(1);
    pb_a[0] = 1'b1; tick(2);
    e = cyc;
    expect_ev(0, 0, K_FALL, e + LAT);
    pb_a[0] = 1'b0;
    tick(60);

    // Simultaneous: ch0 short and ch1 long started on the same cycle
    p = cyc;
    expect_ev(0, 0, K_RISE, p + LAT);
    expect_ev(0, 1, K_RISE, p + LAT);
    expect_ev(0, 0, K_FALL, p + 30 + LAT);
    expect_ev(0, 0, K_SHORT, p + 30 + LAT);
    expect_ev(0, 1, K_LONG, p + LAT + L);
    expect_ev(0, 1, K_FALL, p + 2100 + LAT);
    pb_a = 2'b11;
    tick(30);
    pb_a[0] = 1'b0;
    tick(2070);
    pb_a[1] = 1'b0;
    tick(60);

    // Reset 1000 ms into a ch0 hold
    p = cyc;
    expect_ev(0, 0, K_RISE, p + LAT);
    pb_a[0] = 1'b1;
    tick(1000);
    chk("midpress_held_before", held_a, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    chk("midpress_held",  held_a,  '0);
    chk("midpress_short", short_a, '0);
    chk("midpress_long",  long_a,  '0);
    tick(5);
    rst = 1'b0;
    tick(2500);
    chk("midpress_lockout_held", held_a, '0);
    pb_a[0] = 1'b0;
    tick(100);
    p = cyc;
    expect_ev(0, 0, K_RISE, p + LAT);
    expect_ev(0, 0, K_FALL, p + 30 + LAT);
    expect_ev(0, 0, K_SHORT, p + 30 + LAT);
    pb_a[0] = 1'b1;
    tick(30);
    pb_a[0] = 1'b0;
    tick(60);

    // Every expected event must have been observed
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events not seen, required 0", exp_q.size());
      while (exp_q.size() != 0) begin
        ev_t m;
        m = exp_q.pop_front();
        $display("FAIL missing: dut%0d ch%0d %s @%0d not seen", m.d, m.ch, kname(m.kind), m.cyc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_pushbutton_processor.md
Name: multi_pushbutton_processor

Overview:
- N-channel pushbutton front end for the scoreboard: synchronises, debounces and classifies each button press as short or long, with optional auto-repeat while a button is held.
- Generalises the single-button short/long processor:
  - channel count, debounce time, long-press threshold and repeat interval are parameters;
  - adds a debounced level output and power-on/reset lockout.
- Sits between the board pins and the score counter logic, clocked from the 1 kHz tick clock.

Parameters:
- N_BUTTONS, 2, number of independent button channels (1..8)
- DEBOUNCE_MS, 20, consecutive stable cycles required to accept a level change (>=2)
- LONG_PRESS_MS, 2000, held cycles after debounced press before first long pulse (> DEBOUNCE_MS)
- REPEAT_EN, 0, 1 = emit further long pulses while held
- REPEAT_MS, 250, cycles between repeated long pulses when REPEAT_EN=1 (>=1)

Ports:
- clk_1khz  input  1  system clock, 1 kHz, rising edge
- rst_i  input  1  asynchronous, active-high reset
- pushbutton_i  input  N_BUTTONS  raw asynchronous button levels, 1 = pressed
- held_o  output  N_BUTTONS  debounced button level
- short_o  output  N_BUTTONS  one-cycle pulse: press released before long threshold
- long_o  output  N_BUTTONS  one-cycle pulse: long threshold reached / repeat interval elapsed

Behaviour:
- Clock and reset:
  - Single clock domain: clk_1khz.
  - rst_i asynchronous, active-high; clears all state immediately.
- Reset values: held_o=0, short_o=0, long_o=0; sync flops 0; all counters 0; every channel's lockout flag = 1.
- Channels fully independent. Simultaneous events on different channels are each reported in the same cycle; no priority.
- Synchroniser: 2-flop per bit. sync2 is the synchronised level.
- Debounce (per channel), counter width clog2(DEBOUNCE_MS+1):
  - sync2 == held_o: counter cleared.
  - sync2 != held_o: counter increments.
  - Edge where the counter would reach DEBOUNCE_MS: held_o toggles and the counter clears.
  - Any return to agreement before that clears the counter, so bounces shorter than DEBOUNCE_MS never change held_o.
- Latency: held_o changes DEBOUNCE_MS+2 edges (±1 for input sampling alignment) after pushbutton_i settles.
- Lockout:
  - While lockout=1, held_o is forced 0 and no pulses are emitted.
  - lockout clears once sync2 has been 0 for DEBOUNCE_MS consecutive cycles.
  - A button held through reset release is therefore ignored until released.
- Per-channel FSM:
  - IDLE: held_o=0. On the held_o rise edge → PRESSED, hold counter = 0.
  - PRESSED: hold counter increments each cycle.
    - Counter reaches LONG_PRESS_MS → long_o=1 for that cycle, → LONG.
    - held_o falls first → short_o=1 on the same edge held_o goes low, → IDLE.
  - LONG: with REPEAT_EN=1, the hold counter restarts at 0 after each pulse; long_o=1 each time it reaches REPEAT_MS. On the held_o fall edge → IDLE with no short pulse.
- Hold counter width: clog2(max(LONG_PRESS_MS, REPEAT_MS)+1); it saturates and never wraps.
- short_o and long_o are never both high on one channel in the same cycle. Each is high for exactly one cycle per event.
- A release exactly on the cycle the long threshold is reached counts as long: long_o=1, short_o=0.
- Reset mid-operation: outputs drop asynchronously and no pending pulse is emitted after reset.

Test Plan (defaults unless stated; N_BUTTONS=2):
- Post-reset lockout:
  - pushbutton_i[0]=1 through rst_i deassert, held 100 ms, then released → held_o[0], short_o[0], long_o[0] stay 0 throughout.
  - Next press of 30 ms → exactly one short_o[0] pulse.
- Bounce rejection:
  - ch0 pulses 1/0 with 1–2 ms widths for 8 ms, then stable 1 for 30 ms, then 0 → held_o[0] rises once ~22 ms after the last edge and falls once.
  - Exactly one short_o[0] 1-cycle pulse; long_o[0]=0.
- Long press:
  - ch0 held 2100 ms → long_o[0] single pulse exactly 2000 cycles after held_o[0] rise.
  - No short_o[0] on release.
  - Release bounces of 1–2 ms produce no further pulses.
- Auto-repeat: REPEAT_EN=1, REPEAT_MS=250, ch1 held 2600 ms → long_o[1] pulses at 2000, 2250 and 2500 cycles after held_o[1] rise (3 pulses), then 0 after release.
- Simultaneous channels: ch0 30 ms press and ch1 2100 ms press started in the same cycle → short_o[0] and long_o[1] each fire once; no cross-talk between channels.
- Reset mid-press: rst_i asserted 1000 ms into a ch0 hold, for 5 ms:
  - all outputs 0 immediately;
  - no pulses until ch0 is released (lockout) and pressed again.
